// File: rtl/top_tx_pkg.sv
// Shared UART definitions: FSM state encoding, parity selection and line-level bit constants.
package top_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit from the XOR-reduction of the data and the requested parity type.
  function automatic logic par_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Frame data register and bit counter: holds the accepted word and selects the current
// data bit, LSB first, while the transmitter sits in its DATA state.
module tx_serializer
  import top_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic                  o_ser_data,
  output logic                  o_ser_done
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;

  // Counter is cleared the cycle before DATA and saturates on the last bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_advance && (r_cnt != LAST_IDX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ser_data = r_data[r_cnt];
  assign o_ser_done = (r_cnt == LAST_IDX);

endmodule

// File: rtl/top_tx.sv
// UART transmit top: accepts a parallel word and emits start, data (LSB first),
// optional parity and stop bits at one bit per clock on an idle-high line.
module top_tx
  import top_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  PAR_en,
  input  logic                  PAR_typ,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_e r_state;
  logic      r_par_en;
  logic      r_par_bit;

  logic w_accept;
  logic w_in_start;
  logic w_in_data;
  logic w_ser_data;
  logic w_ser_done;

  // New frames are taken only when idle or while the current stop bit is out.
  assign w_accept   = data_valid && ((r_state == IDLE) || (r_state == STOP));
  assign w_in_start = (r_state == START);
  assign w_in_data  = (r_state == DATA);

  tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_accept),
    .i_data     (p_data),
    .i_clear    (w_in_start),
    .i_advance  (w_in_data),
    .o_ser_data (w_ser_data),
    .o_ser_done (w_ser_done)
  );

  // Line outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      tx_out    <= STOP_BIT;
      busy      <= 1'b0;
    end else begin
      busy <= (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          tx_out <= STOP_BIT;
          if (w_accept) begin
            r_state <= START;
          end
        end
        START: begin
          tx_out  <= START_BIT;
          r_state <= DATA;
        end
        DATA: begin
          tx_out <= w_ser_data;
          if (w_ser_done) begin
            r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          tx_out  <= r_par_bit;
          r_state <= STOP;
        end
        STOP: begin
          tx_out  <= STOP_BIT;
          r_state <= w_accept ? START : IDLE;
        end
        default: begin
          tx_out  <= STOP_BIT;
          r_state <= IDLE;
        end
      endcase
      if (w_accept) begin
        r_par_en  <= PAR_en;
        r_par_bit <= par_bit(^p_data, PAR_typ);
      end
    end
  end

endmodule

// File: tb/tb_top_tx.sv
// Bench for top_tx: directed frames plus random traffic against a bit-queue line model.
module tb_top_tx;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          PAR_en;
  logic          PAR_typ;
  logic          tx_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Bits still owed by the frame in flight; front is the bit the line shows next cycle.
  logic        mq[$];
  logic [31:0] cap;
  int          cap_n;
  int          run;
  int          max_run;

  top_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .PAR_en     (PAR_en),
    .PAR_typ    (PAR_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [DW-1:0] d, input logic en, input logic typ);
    mq.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) mq.push_back(d[i]);
    if (en) mq.push_back((^d) ^ typ);
    mq.push_back(1'b1);
  endfunction

  task automatic cap_clear();
    cap     = '0;
    cap_n   = 0;
    run     = 0;
    max_run = 0;
  endtask

  // One clock: drive inputs, advance the model, then compare the line after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic en, input logic typ);
    logic exp_tx;
    logic exp_busy;
    logic acc;
    data_valid = v;
    p_data     = d;
    PAR_en     = en;
    PAR_typ    = typ;
    exp_tx   = (mq.size() == 0) ? 1'b1 : mq[0];
    exp_busy = (mq.size() != 0);
    acc      = v && (mq.size() <= 1);
    if (mq.size() != 0) void'(mq.pop_front());
    if (acc) push_frame(d, en, typ);
    @(posedge clk);
    #1;
    check("tx_out", 32'(tx_out), 32'(exp_tx));
    check("busy", 32'(busy), 32'(exp_busy));
    if (busy === 1'b1) begin
      if (cap_n < 32) cap[cap_n] = tx_out;
      cap_n++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    PAR_en     = 1'b0;
    PAR_typ    = 1'b0;
    cap_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(20);

    // 0xA5 even parity
    cap_clear();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(13);
    check("a5_even_len", 32'(cap_n), 32'd11);
    check("a5_even_bits", 32'(cap[10:0]), 32'h54A);
    check("a5_even_par", 32'(cap[9]), 32'd0);

    // 0xA5 and 0x07 odd parity
    cap_clear();
    step(1'b1, 8'hA5, 1'b1, 1'b1);
    idle(13);
    check("a5_odd_par", 32'(cap[9]), 32'd1);
    cap_clear();
    step(1'b1, 8'h07, 1'b1, 1'b1);
    idle(13);
    check("x07_odd_par", 32'(cap[9]), 32'd0);

    // 0x3C without parity, 0xFF strobed during its stop cycle
    cap_clear();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(12);
    check("b2b_len", 32'(cap_n), 32'd20);
    check("b2b_run", 32'(max_run), 32'd20);
    check("b2b_bits", 32'(cap[19:0]), 32'({10'h3FE, 10'h278}));

    // Strobe and parity changes mid-frame are ignored
    cap_clear();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 8'h55, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(12);
    check("ignore_len", 32'(cap_n), 32'd11);
    check("ignore_bits", 32'(cap[10:0]), 32'h54A);

    // Reset while data bit 3 is on the line
    step(1'b1, DW'($urandom), 1'b1, 1'b0);
    idle(5);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_tx", 32'(tx_out), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    mq.delete();
    @(posedge clk);
    #1;
    check("midrst_hold_tx", 32'(tx_out), 32'd1);
    check("midrst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(3);
    cap_clear();
    step(1'b1, 8'h81, 1'b1, 1'b0);
    idle(13);
    check("x81_len", 32'(cap_n), 32'd11);
    check("x81_bits", 32'(cap[10:0]), 32'h502);
    check("x81_par", 32'(cap[9]), 32'd0);

    // Random traffic, including strobes that land in every state
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    // Valid held high continuously
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
